// File: rtl/seg7_frame_decoder.sv
// Seven-segment pattern stream to packed BCD frame decoder.
// Collects NUM_DIGITS patterns (MSD first) and holds the frame on a valid/ready port.
module seg7_frame_decoder #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              leds,
  input  logic                    in_first,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = $clog2(NUM_DIGITS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                  r_state, w_state_n;
  logic [CW-1:0]           r_cnt, w_cnt_n;
  logic [4*NUM_DIGITS-1:0] r_bcd, w_bcd_n;
  logic [NUM_DIGITS-1:0]   r_err, w_err_n;
  logic                    r_valid, w_valid_n;

  logic [3:0]    w_nib;
  logic          w_bad;
  logic          w_acc;
  logic          w_restart;
  logic [CW-1:0] w_k;

  always_comb begin
    w_nib = 4'hF;
    w_bad = 1'b0;
    case (leds)
      7'h3F: w_nib = 4'd0;
      7'h06: w_nib = 4'd1;
      7'h5B: w_nib = 4'd2;
      7'h4F: w_nib = 4'd3;
      7'h66: w_nib = 4'd4;
      7'h6D: w_nib = 4'd5;
      7'h7D: w_nib = 4'd6;
      7'h07: w_nib = 4'd7;
      7'h7F: w_nib = 4'd8;
      7'h6F: w_nib = 4'd9;
      default: begin
        w_nib = 4'hF;
        w_bad = 1'b1;
      end
    endcase
  end

  assign in_ready  = (r_state == COLLECT) && !reset;
  assign w_acc     = in_valid && in_ready;
  assign w_restart = in_first || (r_cnt == '0);
  assign w_k       = in_first ? '0 : r_cnt;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bcd_n   = r_bcd;
    w_err_n   = r_err;
    w_valid_n = r_valid;
    case (r_state)
      COLLECT: begin
        if (w_acc) begin
          // resync drops whatever partial frame was collected
          if (in_first) begin
            w_bcd_n = '0;
            w_err_n = '0;
          end
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CW'(NUM_DIGITS - 1 - i) == w_k) begin
              w_bcd_n[4*i +: 4] = w_nib;
              w_err_n[i]        = w_bad;
            end
          end
          if (w_k == CW'(NUM_DIGITS - 1)) begin
            w_cnt_n   = '0;
            w_state_n = HOLD;
            w_valid_n = 1'b1;
          end else begin
            w_cnt_n = w_k + CW'(1);
          end
        end
      end
      HOLD: begin
        if (r_valid && out_ready) begin
          w_valid_n = 1'b0;
          w_state_n = COLLECT;
        end
      end
      default: w_state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_err   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bcd   <= w_bcd_n;
      r_err   <= w_err_n;
      r_valid <= w_valid_n;
    end
  end

  assign bcd_out   = r_bcd;
  assign digit_err = r_err;
  assign out_err   = |r_err;
  assign out_valid = r_valid;

  logic w_unused;
  assign w_unused = w_restart;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder with NUM_DIGITS=4.
// Frame table plus hand-written handshake, resync and reset sequences.
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  leds;
  logic        in_first;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_frame_decoder #(.NUM_DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .leds      (leds),
    .in_first  (in_first),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .digit_err (digit_err),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] pats;
    logic [15:0] bcd;
    logic [3:0]  err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one beat; returns #1 after the accepting edge
  task automatic send(input logic [6:0] p, input logic f);
    int t;
    t = 0;
    @(negedge clk);
    leds     = p;
    in_first = f;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [15:0] b,
                             input logic [3:0] e);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(b));
    chk({name, "_err"}, 32'(digit_err), 32'(e));
    chk({name, "_oerr"}, 32'(out_err), 32'(e != 4'd0));
    chk({name, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_frame(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_rel_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = '{pats: {7'h3F, 7'h06, 7'h5B, 7'h4F}, bcd: 16'h0123, err: 4'b0000};
    tbl[1] = '{pats: {7'h6F, 7'h07, 7'h00, 7'h7F}, bcd: 16'h97F8, err: 4'b0010};
    tbl[2] = '{pats: {7'h6D, 7'h7D, 7'h07, 7'h7F}, bcd: 16'h5678, err: 4'b0000};
    tbl[3] = '{pats: {7'h66, 7'h6D, 7'h7D, 7'h6F}, bcd: 16'h4569, err: 4'b0000};
    tbl[4] = '{pats: {7'h00, 7'h7E, 7'h08, 7'h3E}, bcd: 16'hFFFF, err: 4'b1111};
    tbl[5] = '{pats: {7'h5B, 7'h49, 7'h6D, 7'h7D}, bcd: 16'h2F56, err: 4'b0100};
    tbl[6] = '{pats: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, bcd: 16'h8888, err: 4'b0000};

    reset     = 1'b1;
    leds      = '0;
    in_first  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // back-to-back frame, held ten cycles with out_ready low
    send(7'h3F, 1'b0);
    send(7'h06, 1'b0);
    send(7'h5B, 1'b0);
    chk("partial_valid", 32'(out_valid), 32'd0);
    send(7'h4F, 1'b0);
    check_frame("f0123", 16'h0123, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bcd", 32'(bcd_out), 32'h0123);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    release_frame("f0123");

    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 4; j++)
        send(tbl[v].pats[27-7*j -: 7], j == 0);
      check_frame($sformatf("tbl%0d", v), tbl[v].bcd, tbl[v].err);
      release_frame($sformatf("tbl%0d", v));
    end

    // resync mid-frame
    send(7'h06, 1'b0);
    send(7'h5B, 1'b0);
    send(7'h66, 1'b1);
    chk("resync_v1", 32'(out_valid), 32'd0);
    send(7'h6D, 1'b0);
    send(7'h7D, 1'b0);
    chk("resync_v2", 32'(out_valid), 32'd0);
    send(7'h07, 1'b0);
    check_frame("resync", 16'h4567, 4'b0000);
    release_frame("resync");

    // gapped input, then a beat held valid through HOLD
    for (int j = 0; j < 4; j++) begin
      send(7'h7F, 1'b0);
      @(negedge clk);
    end
    chk("gap_bcd", 32'(bcd_out), 32'h8888);
    chk("gap_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    leds     = 7'h5B;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("holdin_rdy", 32'(in_ready), 32'd0);
      chk("holdin_bcd", 32'(bcd_out), 32'h8888);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("holdin_rel_valid", 32'(out_valid), 32'd0);
    chk("holdin_rel_bcd", 32'(bcd_out), 32'h8888);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("holdin_nib3", 32'(bcd_out[15:12]), 32'h2);
    send(7'h3F, 1'b0);
    send(7'h3F, 1'b0);
    send(7'h3F, 1'b0);
    check_frame("after_hold", 16'h2000, 4'b0000);
    release_frame("after_hold");

    // reset in the middle of a frame
    send(7'h66, 1'b0);
    send(7'h6D, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_rdy", 32'(in_ready), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_post_rdy", 32'(in_ready), 32'd1);
    send(7'h07, 1'b0);
    send(7'h06, 1'b0);
    send(7'h5B, 1'b0);
    chk("midrst_partial", 32'(out_valid), 32'd0);
    send(7'h3F, 1'b0);
    check_frame("midrst", 16'h7120, 4'b0000);
    release_frame("midrst");
    @(negedge clk);
    chk("midrst_once", 32'(out_valid), 32'd0);

    // reset while holding a frame
    for (int j = 0; j < 4; j++) send(7'h06, 1'b0);
    chk("hrst_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("hrst_valid", 32'(out_valid), 32'd0);
    chk("hrst_bcd", 32'(bcd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("hrst_rdy", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
